ysyx_22040175_dmem_resp: RTL and testbench
==========================================

# ysyx_22040175_dmem_resp

Data-memory responder for the 5-stage core. It is the target side of the load/store request issued by the memory stage: it accepts one request at a time over a valid/ready handshake and services it against an internal 64-bit-wide SRAM array. It returns read data, or a write acknowledgement, after a fixed programmable latency over a second valid/ready handshake. Load sign/zero extension stays with the requester; this block only moves whole doublewords under byte masks.

## Interface
- ADDR_WIDTH, 12: log2 of word depth (4096 × 64-bit words = 32 KiB).
- LATENCY, 2: cycles from request acceptance to resp_valid; legal range 1..15.
- MEM_BASE, 64'h8000_0000: byte address of word 0.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address; bits [2:0] ignored.
- req_wdata  in  64  store data, lane-aligned.
- req_wmask  in  8  byte-lane write enables; ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts response.
- resp_rdata  out  64  load data (0 for stores).
- resp_err  out  1  address outside array.

## Operation
- State machine: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch wen/addr/wdata/wmask, load counter with LATENCY-1, go to WAIT (LATENCY=1 goes to WAIT with counter 0).
- WAIT: req_ready=0. Counter decrements each cycle. When the counter is 0, perform the access on that edge and go to RESP.
  - Load: resp_rdata ← mem[idx].
  - Store: for each i with wmask[i]=1, mem[idx] byte i ← wdata byte i; resp_rdata ← 0.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_valid&&resp_ready, then go to IDLE.
- Index: idx = (req_addr - MEM_BASE) >> 3, truncated to ADDR_WIDTH bits. In range iff (req_addr - MEM_BASE) < 2^(ADDR_WIDTH+3), evaluated with unsigned 64-bit arithmetic, so addresses below MEM_BASE wrap large and are out of range.
- Out of range: behaviour is set by the macro in Configuration.
- Store with wmask=0: full handshake, array unchanged.
- Array contents are not reset; only control and output registers are.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
- Request accepted at edge T → resp_valid=1 from edge T+LATENCY.
- Minimum request-to-request spacing: LATENCY+2 cycles. There is no acceptance in the cycle of response handshake.
- req_ready and resp_valid are never both 1.
- resp_valid is not withdrawn before resp_ready. resp_ready held low stalls indefinitely with outputs constant.
- Load after store to the same word observes the stored data, because the write commits before the load's request is accepted.
- Reset asserted mid-operation: immediate return to IDLE, resp_valid drops.
  - Asserted in WAIT: a store is not committed.
  - Asserted in RESP: the store has already committed.

## Configuration
- DMEM_ERR_EN defined: an out-of-range access sets resp_err=1 and resp_rdata=0, and a store does not write the array. The latency and handshake are unchanged.
- DMEM_ERR_EN undefined: resp_err is tied to 0. The index is simply the truncated value, so out-of-range addresses alias modulo the array size, and loads and stores proceed normally.

## Test plan
- Reset release, idle: req_ready=1, resp_valid=0, resp_rdata=0 until the first request.
- Store 0x1122_3344_5566_7788 to 0x8000_0010 with wmask=8'hFF, then load 0x8000_0010 with LATENCY=2: resp_valid exactly 2 cycles after each acceptance, and the load returns 0x1122334455667788.
- Store 0xAAAA_AAAA_AAAA_AAAA to 0x8000_0010 with wmask=8'h0F, then load: the load returns 0x11223344AAAAAAAA.
- Load 0x8000_0010 with resp_ready held low for 5 cycles: resp_valid and resp_rdata stay stable, req_ready=0 throughout, and IDLE is reached one cycle after resp_ready rises.
- Load 0x7FFF_FFF8 with DMEM_ERR_EN defined: resp_err=1, resp_rdata=0. Without DMEM_ERR_EN, the same access returns mem[4095] with resp_err=0.
- Store issued, rst_n pulsed low during WAIT, then load the same address: the old contents are returned, and resp_valid=0 immediately at reset.

Source files
------------

// File: rtl/ysyx_22040175_dmem_resp.sv
// -----------------------------------------------------------------------------
// ysyx_22040175_dmem_resp
//
// Data-memory responder for the 5-stage core. Target side of the memory
// stage's load/store request. Accepts one request at a time over a
// valid/ready handshake. Services it against an internal 64-bit-wide SRAM
// array, then returns read data or a write acknowledgement after a fixed
// latency over a second valid/ready handshake. Only whole doublewords move
// here, under byte masks; load sign/zero extension belongs to the requester.
//
// Parameters
//   ADDR_WIDTH  log2 of word depth (default 12 -> 4096 x 64-bit = 32 KiB)
//   LATENCY     cycles from request acceptance to resp_valid, legal 1..15
//   MEM_BASE    byte address of word 0
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  responder can accept (high only while idle)
//   req_wen     in   1 = store, 0 = load
//   req_addr    in   byte address, bits [2:0] ignored
//   req_wdata   in   store data, lane-aligned
//   req_wmask   in   byte-lane write enables, ignored for loads
//   resp_valid  out  response present
//   resp_ready  in   requester accepts response
//   resp_rdata  out  load data (0 for stores and error responses)
//   resp_err    out  address outside the array
//
// Configuration macro
//   DMEM_ERR_EN  When defined, out-of-range accesses report resp_err=1 and
//                return 0, and out-of-range stores leave the array untouched.
//                When undefined, resp_err is tied to 0 and out-of-range
//                addresses alias modulo the array size.
// -----------------------------------------------------------------------------
module ysyx_22040175_dmem_resp #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          LATENCY    = 2,
  parameter logic [63:0] MEM_BASE   = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  // The counter starts at LATENCY-1. The access happens on the edge where it
  // reads zero, so resp_valid rises exactly LATENCY edges after acceptance.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Control and output registers
  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [63:0]         r_resp_rdata;
  logic                r_resp_err;

  // Latched request payload
  logic                r_wen;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                r_oor;
  logic [63:0]         r_wdata;
  logic [7:0]          r_wmask;

  // Storage array
  logic [63:0]         r_mem [DEPTH];

  // The offset is computed in unsigned 64-bit arithmetic. An address below
  // MEM_BASE therefore wraps to a huge offset and lands out of range.
  logic [63:0]         w_req_off;
  logic                w_req_oor;
  logic                w_accept;
  logic                w_fire;
  logic                w_err;
  logic                w_mem_we;
  logic                w_unused_bits;

  assign w_req_off = req_addr - MEM_BASE;
  assign w_req_oor = |w_req_off[63:ADDR_WIDTH+3];

  assign w_accept  = (r_state == S_IDLE) && req_valid && r_req_ready;
  assign w_fire    = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef DMEM_ERR_EN
  assign w_err     = r_oor;
`else
  // Errors are disabled, so the truncated index simply aliases.
  assign w_err     = 1'b0;
`endif

  // A store writes the array only on the commit edge. Reset that lands while
  // the request is in WAIT returns the FSM to IDLE first, so that store is
  // dropped.
  assign w_mem_we  = w_fire && r_wen && !w_err;

  // Byte-offset bits never select anything, and the range flag is only used
  // when errors are enabled.
  assign w_unused_bits = ^{w_req_off[2:0], r_oor};

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt       <= CNT_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            // The array is read and written on this same edge. A store
            // acknowledges with zero data, and so does an error response.
            r_resp_rdata <= (r_wen || w_err) ? 64'd0 : r_mem[r_idx];
            r_resp_err   <= w_err;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_RESP: begin
          // Hold data stable until taken. Acceptance reopens only on the edge
          // after the handshake, so the two valids never overlap.
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request payload capture
  // ---------------------------------------------------------------------------
  // NOTE: the payload and the array have no reset. They are only consumed
  // while r_state (which is reset) says they are valid. Leaving them unreset
  // keeps the array mappable onto plain SRAM.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wen   <= req_wen;
      r_idx   <= w_req_off[ADDR_WIDTH+2:3];
      r_oor   <= w_req_oor;
      r_wdata <= req_wdata;
      r_wmask <= req_wmask;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array with byte-lane writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (w_mem_we && r_wmask[b]) begin
        r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_ysyx_22040175_dmem_resp.sv
// -----------------------------------------------------------------------------
// Testbench for ysyx_22040175_dmem_resp.
//
// The bench runs a table of directed load/store transactions, each with a
// hand-computed response. It then runs hand-written sequences for reset
// during WAIT and reset during RESP. Expected values for out-of-range
// accesses follow DMEM_ERR_EN, so the same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_ysyx_22040175_dmem_resp;

  localparam int LAT = 2;

`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  ysyx_22040175_dmem_resp #(
    .ADDR_WIDTH(12),
    .LATENCY   (LAT),
    .MEM_BASE  (64'h8000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          stall;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic wen, logic [63:0] a,
                              logic [63:0] d, logic [7:0] m, int st,
                              logic [63:0] er, logic ee);
    vec_t v;
    v.name = nm; v.wen = wen; v.addr = a; v.wdata = d; v.wmask = m;
    v.stall = st; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for req_ready, then present the request for one edge.
  task automatic issue(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({v.name, " ready_before_issue"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_wen   = v.wen;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wmask = v.wmask;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called right after the accepting edge. Checks latency, data, stalling
  // and the return to idle.
  task automatic collect(input vec_t v);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      check({v.name, " ready_busy"}, 64'(req_ready), 64'd0);
      if (k < LAT) check({v.name, " valid_early"}, 64'(resp_valid), 64'd0);
      else         check({v.name, " valid_on_time"}, 64'(resp_valid), 64'd1);
    end
    check({v.name, " rdata"}, resp_rdata, v.exp_rdata);
    check({v.name, " err"}, 64'(resp_err), 64'(v.exp_err));
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk);
      #1;
      check({v.name, " stall_valid"}, 64'(resp_valid), 64'd1);
      check({v.name, " stall_rdata"}, resp_rdata, v.exp_rdata);
      check({v.name, " stall_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({v.name, " valid_drop"}, 64'(resp_valid), 64'd0);
    check({v.name, " idle_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic run(input vec_t v);
    issue(v);
    collect(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running required finished");
    $fatal(1);
  end

  initial begin
    vec_t v;

    // Transaction table (LAT=2). Rows depend on earlier rows' stores.
    vecs.push_back(mk("st_full",  1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'd0, 0));
    vecs.push_back(mk("ld_full",  0, 64'h8000_0010, 64'd0, 8'h00, 0, 64'h1122_3344_5566_7788, 0));
    vecs.push_back(mk("st_lo",    1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 64'd0, 0));
    vecs.push_back(mk("ld_merge", 0, 64'h8000_0010, 64'd0, 8'h00, 0, 64'h1122_3344_AAAA_AAAA, 0));
    vecs.push_back(mk("ld_stall", 0, 64'h8000_0010, 64'd0, 8'h00, 5, 64'h1122_3344_AAAA_AAAA, 0));
    vecs.push_back(mk("st_w3",    1, 64'h8000_0018, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 64'd0, 0));
    vecs.push_back(mk("st_nomsk", 1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 64'd0, 0));
    vecs.push_back(mk("ld_nomsk", 0, 64'h8000_001F, 64'd0, 8'h00, 0, 64'h0123_4567_89AB_CDEF, 0));
    vecs.push_back(mk("st_w4",    1, 64'h8000_0020, 64'd0, 8'hFF, 0, 64'd0, 0));
    vecs.push_back(mk("st_m81",   1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 0, 64'd0, 0));
    vecs.push_back(mk("ld_m81",   0, 64'h8000_0020, 64'd0, 8'h00, 0, 64'hFF00_0000_0000_00FF, 0));
    vecs.push_back(mk("st_top",   1, 64'h8000_7FF8, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 64'd0, 0));
    vecs.push_back(mk("ld_top",   0, 64'h8000_7FF8, 64'd0, 8'h00, 0, 64'hCAFE_F00D_1234_5678, 0));
    vecs.push_back(mk("ld_below", 0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0,
                      ERR_EN ? 64'd0 : 64'hCAFE_F00D_1234_5678, ERR_EN));
    vecs.push_back(mk("st_w0",    1, 64'h8000_0000, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 0, 64'd0, 0));
    vecs.push_back(mk("st_oor",   1, 64'h8000_8000, 64'h5555_5555_5555_5555, 8'hFF, 0, 64'd0, ERR_EN));
    vecs.push_back(mk("ld_w0",    0, 64'h8000_0000, 64'd0, 8'h00, 0,
                      ERR_EN ? 64'h0F0F_0F0F_0F0F_0F0F : 64'h5555_5555_5555_5555, 0));

    // Reset and idle behaviour
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    req_wmask  = 8'd0;
    resp_ready = 1'b0;
    #23;
    check("rst ready", 64'(req_ready), 64'd1);
    check("rst valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle ready", 64'(req_ready), 64'd1);
      check("idle valid", 64'(resp_valid), 64'd0);
      check("idle rdata", resp_rdata, 64'd0);
      check("idle err",   64'(resp_err), 64'd0);
    end

    foreach (vecs[i]) run(vecs[i]);

    // Reset during WAIT: the store must not commit.
    v = mk("st_rst_wait", 1, 64'h8000_0010, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 64'd0, 0);
    issue(v);
    rst_n = 1'b0;
    #1;
    check("rst_wait valid", 64'(resp_valid), 64'd0);
    check("rst_wait ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run(mk("ld_after_wait_rst", 0, 64'h8000_0010, 64'd0, 8'h00, 0, 64'h1122_3344_AAAA_AAAA, 0));

    // Reset during RESP: the store has already committed.
    v = mk("st_rst_resp", 1, 64'h8000_0010, 64'h0BAD_C0DE_0BAD_C0DE, 8'hFF, 0, 64'd0, 0);
    issue(v);
    repeat (LAT) @(posedge clk);
    #1;
    check("rst_resp valid_before", 64'(resp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_resp valid", 64'(resp_valid), 64'd0);
    check("rst_resp ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run(mk("ld_after_resp_rst", 0, 64'h8000_0010, 64'd0, 8'h00, 0, 64'h0BAD_C0DE_0BAD_C0DE, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
